// File: rtl/quat_pkg.sv
// Shared widths, defaults and saturation limits for the quaternion datapath.
package quat_pkg;

    localparam int unsigned OP_W          = 16;
    localparam int unsigned PROD_W        = 32;
    localparam int unsigned ACC_W         = PROD_W + 1;
    localparam int unsigned LANES         = 4;
    localparam int unsigned FRAC_BITS_DEF = 14;
    localparam int unsigned SAT_CNT_W_DEF = 16;

    localparam logic signed [OP_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [OP_W-1:0] Q_MIN = 16'sh8000;

    // Saturated result for one lane.
    typedef struct packed {
        logic            sat;
        logic [OP_W-1:0] q;
    } lane_res_t;

endpackage

// File: rtl/quat_requant_lane.sv
// One lane of requantisation: round-half-up and arithmetic shift (first stage),
// and clamp to a 16-bit signed operand (second stage). Purely combinational.
module quat_requant_lane
    import quat_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [PROD_W-1:0] i_c,
    output logic signed [ACC_W-1:0]  o_s_c,
    input  logic signed [ACC_W-1:0]  i_s,
    output lane_res_t                o_res_c
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-OP_W){Q_MAX[OP_W-1]}}, Q_MAX};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-OP_W){Q_MIN[OP_W-1]}}, Q_MIN};

    logic signed [ACC_W-1:0] w_r;

    // One bit of headroom keeps the rounding add from overflowing.
    assign w_r   = {i_c[PROD_W-1], i_c} + HALF;
    assign o_s_c = w_r >>> FRAC_BITS;

    always_comb begin
        o_res_c.q   = i_s[OP_W-1:0];
        o_res_c.sat = 1'b0;
        if (i_s > S_MAX) begin
            o_res_c.q   = Q_MAX;
            o_res_c.sat = 1'b1;
        end else if (i_s < S_MIN) begin
            o_res_c.q   = Q_MIN;
            o_res_c.sat = 1'b1;
        end
    end

endmodule

// File: rtl/quat_requant.sv
// Two-stage valid/ready requantiser: four 32-bit product lanes back to Q2.14
// operands, with per-lane saturation flags and saturation statistics.
module quat_requant
    import quat_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
    parameter int unsigned SAT_CNT_W = SAT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PROD_W-1:0]    in_c0,
    input  logic [PROD_W-1:0]    in_c1,
    input  logic [PROD_W-1:0]    in_c2,
    input  logic [PROD_W-1:0]    in_c3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_q0,
    output logic [OP_W-1:0]      out_q1,
    output logic [OP_W-1:0]      out_q2,
    output logic [OP_W-1:0]      out_q3,
    output logic [LANES-1:0]     out_sat,
    input  logic                 clr_stats,
    output logic [SAT_CNT_W-1:0] sat_cnt,
    output logic                 sat_sticky
);

    logic signed [PROD_W-1:0] w_c     [LANES];
    logic signed [ACC_W-1:0]  w_s     [LANES];
    lane_res_t                w_res   [LANES];
    logic signed [ACC_W-1:0]  r_s1_s  [LANES];
    logic [OP_W-1:0]          r_q     [LANES];
    logic [LANES-1:0]         r_sat;
    logic                     r_s1_valid;
    logic                     r_s2_valid;
    logic [SAT_CNT_W-1:0]     r_sat_cnt;
    logic                     r_sat_sticky;
    logic                     w_adv1;
    logic                     w_adv2;
    logic                     w_count;

    assign w_c[0] = in_c0;
    assign w_c[1] = in_c1;
    assign w_c[2] = in_c2;
    assign w_c[3] = in_c3;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        quat_requant_lane #(
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .i_c     (w_c[g]),
            .o_s_c   (w_s[g]),
            .i_s     (r_s1_s[g]),
            .o_res_c (w_res[g])
        );
    end

    // A stage may load when it is empty or its contents move on this edge.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sat      <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_s[i] <= '0;
                r_q[i]    <= '0;
            end
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_s1_s[i] <= w_s[i];
                    end
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_q[i]   <= w_res[i].q;
                        r_sat[i] <= w_res[i].sat;
                    end
                end
            end
        end
    end

    // Stats follow output handshakes only; a clear overrides a same-cycle count.
    assign w_count = r_s2_valid && out_ready && (|r_sat);

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_sat_cnt    <= '0;
            r_sat_sticky <= 1'b0;
        end else if (w_count) begin
            r_sat_sticky <= 1'b1;
            if (r_sat_cnt != {SAT_CNT_W{1'b1}}) begin
                r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_q0     = r_q[0];
    assign out_q1     = r_q[1];
    assign out_q2     = r_q[2];
    assign out_q3     = r_q[3];
    assign out_sat    = r_sat;
    assign sat_cnt    = r_sat_cnt;
    assign sat_sticky = r_sat_sticky;

endmodule

// File: tb/tb_quat_requant.sv
// Directed bench for quat_requant: vector table plus backpressure, stats and reset sequences.
module tb_quat_requant;

    localparam int unsigned NV = 6;

    typedef struct packed {
        logic [3:0][31:0] c;
        logic [3:0][15:0] q;
        logic [3:0]       sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_c0 = '0;
    logic [31:0] in_c1 = '0;
    logic [31:0] in_c2 = '0;
    logic [31:0] in_c3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_q0, out_q1, out_q2, out_q3;
    logic [3:0]  out_sat;
    logic        clr_stats = 1'b0;
    logic [2:0]  sat_cnt;
    logic        sat_sticky;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl [NV];

    quat_requant #(
        .FRAC_BITS (14),
        .SAT_CNT_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_c0      (in_c0),
        .in_c1      (in_c1),
        .in_c2      (in_c2),
        .in_c3      (in_c3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q0     (out_q0),
        .out_q1     (out_q1),
        .out_q2     (out_q2),
        .out_q3     (out_q3),
        .out_sat    (out_sat),
        .clr_stats  (clr_stats),
        .sat_cnt    (sat_cnt),
        .sat_sticky (sat_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input logic [15:0] q0, input logic [15:0] q1,
                                input logic [15:0] q2, input logic [15:0] q3,
                                input logic [3:0] sat);
        vec_t v;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        v.q[0] = q0; v.q[1] = q1; v.q[2] = q2; v.q[3] = q3;
        v.sat  = sat;
        return v;
    endfunction

    // Distinct non-saturating stream item k: q = {k, -(k+1), 1000k, k+1 (from k+0.5)}.
    function automatic vec_t bp_item(input int k);
        return mk(32'(k) << 14, -(32'(k + 1) << 14), 32'(k * 1000) << 14,
                  32'h0000_2000 + (32'(k) << 14),
                  16'(k), 16'(-(k + 1)), 16'(k * 1000), 16'(k + 1), 4'b0000);
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        in_valid = valid;
        in_c0 = v.c[0];
        in_c1 = v.c[1];
        in_c2 = v.c[2];
        in_c3 = v.c[3];
    endtask

    task automatic check_out(input vec_t v, input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_q0"}, 32'(out_q0), 32'(v.q[0]));
        check({tag, "_q1"}, 32'(out_q1), 32'(v.q[1]));
        check({tag, "_q2"}, 32'(out_q2), 32'(v.q[2]));
        check({tag, "_q3"}, 32'(out_q3), 32'(v.q[3]));
        check({tag, "_sat"}, 32'(out_sat), 32'(v.sat));
    endtask

    initial begin
        int   model_cnt;
        logic model_sticky;
        int   nin;
        int   nout;
        int   cyc;
        logic acc_in;
        logic acc_out;
        vec_t exp_v;

        tbl[0] = mk(32'h1000_0000, 32'h0, 32'h0, 32'h0,
                    16'h4000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
        tbl[1] = mk(32'h0000_2000, 32'hFFFF_E000, 32'h0000_1FFF, 32'hFFFF_DFFF,
                    16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 4'b0000);
        tbl[2] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'h1FFF_C000, 32'h2000_0000,
                    16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 4'b1011);
        tbl[3] = mk(32'hF000_0000, 32'hE000_0000, 32'hDFFF_C000, 32'h0000_6000,
                    16'hC000, 16'h8000, 16'h8000, 16'h0002, 4'b0100);
        tbl[4] = mk(32'h0000_A000, 32'hFFFF_6000, 32'h1FFF_DFFF, 32'h0000_0000,
                    16'h0003, 16'hFFFE, 16'h7FFF, 16'h0000, 4'b0000);
        tbl[5] = mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                    16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b1111);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q0", 32'(out_q0), 32'd0);
        check("rst_sat", 32'(out_sat), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_sticky", 32'(sat_sticky), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table, streamed back to back
        model_cnt    = 0;
        model_sticky = 1'b0;
        for (int i = 0; i <= int'(NV); i++) begin
            if (i < int'(NV)) drive(tbl[i], 1'b1);
            else in_valid = 1'b0;
            #1;
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            if (i >= 1) begin
                check_out(tbl[i-1], $sformatf("tbl%0d", i - 1));
                check($sformatf("tbl%0d_cnt", i - 1), 32'(sat_cnt), 32'(model_cnt));
                check($sformatf("tbl%0d_sticky", i - 1), 32'(sat_sticky), 32'(model_sticky));
                if (tbl[i-1].sat != 4'b0000) begin
                    model_sticky = 1'b1;
                    if (model_cnt < 7) model_cnt++;
                end
            end
        end
        tick();
        check("tbl_end_valid", 32'(out_valid), 32'd0);
        check("tbl_end_cnt", 32'(sat_cnt), 32'(model_cnt));
        check("tbl_end_sticky", 32'(sat_sticky), 32'(model_sticky));

        // Statistics clear
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_cnt", 32'(sat_cnt), 32'd0);
        check("clr_sticky", 32'(sat_sticky), 32'd0);

        // Clear wins over a counted handshake in the same cycle
        drive(tbl[5], 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("clrwin_valid", 32'(out_valid), 32'd1);
        check("clrwin_sat", 32'(out_sat), 32'hF);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clrwin_cnt", 32'(sat_cnt), 32'd0);
        check("clrwin_sticky", 32'(sat_sticky), 32'd0);
        check("clrwin_drained", 32'(out_valid), 32'd0);

        // Backpressure: 8 items, out_ready low for cycles 3..6
        nin  = 0;
        nout = 0;
        cyc  = 0;
        while (nout < 8 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (nin < 8) drive(bp_item(nin), 1'b1);
            else in_valid = 1'b0;
            #1;
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (cyc >= 3 && cyc <= 6) check($sformatf("bp_stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
            if (cyc >= 7) check($sformatf("bp_tput_c%0d", cyc), 32'(out_valid), 32'd1);
            if (acc_out) begin
                exp_v = bp_item(nout);
                check($sformatf("bp_item%0d_q0", nout), 32'(out_q0), 32'(exp_v.q[0]));
                check($sformatf("bp_item%0d_q1", nout), 32'(out_q1), 32'(exp_v.q[1]));
                check($sformatf("bp_item%0d_q2", nout), 32'(out_q2), 32'(exp_v.q[2]));
                check($sformatf("bp_item%0d_q3", nout), 32'(out_q3), 32'(exp_v.q[3]));
                check($sformatf("bp_item%0d_sat", nout), 32'(out_sat), 32'd0);
                nout++;
            end
            @(posedge clk);
            #1;
            if (acc_in) nin++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_outputs", 32'(nout), 32'd8);
        check("bp_cycles", 32'(cyc), 32'd14);
        tick();
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Counter ceiling: 9 saturated outputs with a 3-bit counter
        for (int k = 0; k < 9; k++) begin
            drive(tbl[5], 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("ceil_cnt", 32'(sat_cnt), 32'd7);
        check("ceil_sticky", 32'(sat_sticky), 32'd1);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(tbl[2], 1'b1);
        tick();
        drive(tbl[3], 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_q0", 32'(out_q0), 32'd0);
        check("mrst_q1", 32'(out_q1), 32'd0);
        check("mrst_sat", 32'(out_sat), 32'd0);
        check("mrst_cnt", 32'(sat_cnt), 32'd0);
        check("mrst_sticky", 32'(sat_sticky), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mrst_stale_%0d", k), 32'(out_valid), 32'd0);
        end
        drive(tbl[0], 1'b1);
        #1;
        check("mrst_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("mrst_lat1", 32'(out_valid), 32'd0);
        tick();
        check_out(tbl[0], "mrst_first");
        check("mrst_first_cnt", 32'(sat_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
